// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between commit and the mcsr block.
// Arbitrates exception > mret > interrupt (MEI > MSI > MTI) in IDLE. It then
// drives the mcsr hardware write ports for one cycle (ENTER or LEAVE). It also
// holds a fetch redirect in REDIRECT until fetch accepts it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   exc_valid/code/pc/tval   exception from the committing instruction
//   mret                     committing instruction is mret
//   commit_valid, commit_pc  instruction boundary for interrupt entry
//   irq_software/timer/external  level interrupt lines
//   mstatus_*, mie_*, mtvec_*, mepc_value  current mcsr state
//   i_*                      mcsr hardware write data and write enables
//   flush                    kill in-flight instructions
//   redirect_valid/pc/ready  fetch redirect handshake
//
// Configuration macro: TRAP_CTRL_IRQ_SYNC_EN adds a 2-flop synchronizer on
// each irq line ahead of prioritization and the mip outputs.
module trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        irq_software,
   input  logic        irq_timer,
   input  logic        irq_external,
   input  logic        mstatus_mie,
   input  logic        mstatus_mpie,
   input  logic        mie_msie,
   input  logic        mie_mtie,
   input  logic        mie_meie,
   input  logic [29:0] mtvec_base,
   input  logic [1:0]  mtvec_mode,
   input  logic [31:0] mepc_value,
   output logic [31:0] i_mepc_value,
   output logic        i_mepc_value_wen,
   output logic        i_mcause_interrupt,
   output logic        i_mcause_interrupt_wen,
   output logic [30:0] i_mcause_exception_code,
   output logic        i_mcause_exception_code_wen,
   output logic [31:0] i_mtval_value,
   output logic        i_mtval_value_wen,
   output logic        i_mstatus_mie,
   output logic        i_mstatus_mie_wen,
   output logic        i_mstatus_mpie,
   output logic        i_mstatus_mpie_wen,
   output logic        i_mip_msip,
   output logic        i_mip_msip_wen,
   output logic        i_mip_mtip,
   output logic        i_mip_mtip_wen,
   output logic        i_mip_meip,
   output logic        i_mip_meip_wen,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   typedef enum logic [1:0] {IDLE, ENTER, LEAVE, REDIRECT} state_t;

   state_t      state;
   logic [30:0] code_q;
   logic [31:0] pc_q;
   logic [31:0] tval_q;
   logic        flag_q;

   logic        irq_sw, irq_tm, irq_ex;
   logic        pend_ms, pend_mt, pend_me, irq_take;
   logic [4:0]  irq_code;
   logic [31:0] tvec_base, enter_target;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
   logic [2:0] sync1, sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {irq_external, irq_timer, irq_software};
         sync2 <= sync1;
      end
   end

   assign {irq_ex, irq_tm, irq_sw} = sync2;
`else
   assign {irq_ex, irq_tm, irq_sw} = {irq_external, irq_timer, irq_software};
`endif

   assign i_mip_msip     = irq_sw;
   assign i_mip_mtip     = irq_tm;
   assign i_mip_meip     = irq_ex;
   assign i_mip_msip_wen = 1'b1;
   assign i_mip_mtip_wen = 1'b1;
   assign i_mip_meip_wen = 1'b1;

   assign pend_ms  = irq_sw & mie_msie;
   assign pend_mt  = irq_tm & mie_mtie;
   assign pend_me  = irq_ex & mie_meie;
   assign irq_take = commit_valid & mstatus_mie & (pend_ms | pend_mt | pend_me);

   always_comb begin
      if (pend_me)      irq_code = 5'd11;
      else if (pend_ms) irq_code = 5'd3;
      else              irq_code = 5'd7;
   end

   // Vectored mode only applies to interrupts; modes 2/3 behave as direct.
   assign tvec_base    = {mtvec_base, 2'b00};
   assign enter_target = (mtvec_mode == 2'd1 && flag_q)
                         ? tvec_base + {code_q[29:0], 2'b00} : tvec_base;

   // Flush is raised in the detect cycle itself, ahead of the state change.
   assign flush = (state != IDLE) ||
                  (exc_valid || mret || irq_take);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         code_q      <= '0;
         pc_q        <= '0;
         tval_q      <= '0;
         flag_q      <= 1'b0;
         redirect_pc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (exc_valid) begin
                  code_q <= {26'b0, exc_code};
                  pc_q   <= exc_pc;
                  tval_q <= exc_tval;
                  flag_q <= 1'b0;
                  state  <= ENTER;
               end else if (mret) begin
                  state  <= LEAVE;
               end else if (irq_take) begin
                  code_q <= {26'b0, irq_code};
                  pc_q   <= commit_pc;
                  tval_q <= '0;
                  flag_q <= 1'b1;
                  state  <= ENTER;
               end
            end
            ENTER: begin
               redirect_pc <= enter_target;
               state       <= REDIRECT;
            end
            LEAVE: begin
               redirect_pc <= mepc_value;
               state       <= REDIRECT;
            end
            REDIRECT: begin
               if (redirect_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      i_mepc_value                = '0;
      i_mepc_value_wen            = 1'b0;
      i_mcause_interrupt          = 1'b0;
      i_mcause_interrupt_wen      = 1'b0;
      i_mcause_exception_code     = '0;
      i_mcause_exception_code_wen = 1'b0;
      i_mtval_value               = '0;
      i_mtval_value_wen           = 1'b0;
      i_mstatus_mie               = 1'b0;
      i_mstatus_mie_wen           = 1'b0;
      i_mstatus_mpie              = 1'b0;
      i_mstatus_mpie_wen          = 1'b0;
      redirect_valid              = 1'b0;
      case (state)
         ENTER: begin
            i_mepc_value                = pc_q;
            i_mepc_value_wen            = 1'b1;
            i_mcause_interrupt          = flag_q;
            i_mcause_interrupt_wen      = 1'b1;
            i_mcause_exception_code     = code_q;
            i_mcause_exception_code_wen = 1'b1;
            i_mtval_value               = tval_q;
            i_mtval_value_wen           = 1'b1;
            i_mstatus_mie               = 1'b0;
            i_mstatus_mie_wen           = 1'b1;
            i_mstatus_mpie              = mstatus_mie;
            i_mstatus_mpie_wen          = 1'b1;
         end
         LEAVE: begin
            i_mstatus_mie      = mstatus_mpie;
            i_mstatus_mie_wen  = 1'b1;
            i_mstatus_mpie     = 1'b1;
            i_mstatus_mpie_wen = 1'b1;
         end
         REDIRECT: redirect_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl (default build, no irq synchronizer).
module tb_trap_ctrl;

   logic        clk, rst;
   logic        exc_valid, mret, commit_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc, exc_tval, commit_pc, mepc_value;
   logic        irq_software, irq_timer, irq_external;
   logic        mstatus_mie, mstatus_mpie, mie_msie, mie_mtie, mie_meie;
   logic [29:0] mtvec_base;
   logic [1:0]  mtvec_mode;
   logic [31:0] i_mepc_value, i_mtval_value, redirect_pc;
   logic [30:0] i_mcause_exception_code;
   logic        i_mepc_value_wen, i_mcause_interrupt, i_mcause_interrupt_wen;
   logic        i_mcause_exception_code_wen, i_mtval_value_wen;
   logic        i_mstatus_mie, i_mstatus_mie_wen, i_mstatus_mpie, i_mstatus_mpie_wen;
   logic        i_mip_msip, i_mip_msip_wen, i_mip_mtip, i_mip_mtip_wen;
   logic        i_mip_meip, i_mip_meip_wen;
   logic        flush, redirect_valid, redirect_ready;

   int unsigned total = 0;
   int unsigned bad   = 0;

   trap_ctrl dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret(mret), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .irq_software(irq_software), .irq_timer(irq_timer), .irq_external(irq_external),
      .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
      .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
      .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .mepc_value(mepc_value),
      .i_mepc_value(i_mepc_value), .i_mepc_value_wen(i_mepc_value_wen),
      .i_mcause_interrupt(i_mcause_interrupt), .i_mcause_interrupt_wen(i_mcause_interrupt_wen),
      .i_mcause_exception_code(i_mcause_exception_code),
      .i_mcause_exception_code_wen(i_mcause_exception_code_wen),
      .i_mtval_value(i_mtval_value), .i_mtval_value_wen(i_mtval_value_wen),
      .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mie_wen(i_mstatus_mie_wen),
      .i_mstatus_mpie(i_mstatus_mpie), .i_mstatus_mpie_wen(i_mstatus_mpie_wen),
      .i_mip_msip(i_mip_msip), .i_mip_msip_wen(i_mip_msip_wen),
      .i_mip_mtip(i_mip_mtip), .i_mip_mtip_wen(i_mip_mtip_wen),
      .i_mip_meip(i_mip_meip), .i_mip_meip_wen(i_mip_meip_wen),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", redirect_valid); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush); end
      total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", redirect_pc); end
      total++; if ({i_mepc_value_wen, i_mcause_interrupt_wen, i_mtval_value_wen, i_mstatus_mie_wen} !== 4'b0)
         begin bad++; $display("FAIL rst_wen got=%b exp=0000", {i_mepc_value_wen, i_mcause_interrupt_wen, i_mtval_value_wen, i_mstatus_mie_wen}); end
   endtask

   task automatic test_exception;
      mtvec_base = 30'h80; mtvec_mode = 2'd0; mstatus_mie = 1'b1; mstatus_mpie = 1'b0;
      exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL exc_flush_T got=%b exp=1", flush); end
      tick();
      exc_valid = 1'b0;
      #1;
      total++; if (i_mepc_value !== 32'h100 || i_mepc_value_wen !== 1'b1) begin bad++; $display("FAIL exc_mepc got=%h/%b exp=100/1", i_mepc_value, i_mepc_value_wen); end
      total++; if ({i_mcause_interrupt, i_mcause_exception_code} !== 32'h2) begin bad++; $display("FAIL exc_mcause got=%h exp=00000002", {i_mcause_interrupt, i_mcause_exception_code}); end
      total++; if (i_mtval_value !== 32'hDEAD || i_mtval_value_wen !== 1'b1) begin bad++; $display("FAIL exc_mtval got=%h exp=dead", i_mtval_value); end
      total++; if ({i_mstatus_mie, i_mstatus_mie_wen, i_mstatus_mpie, i_mstatus_mpie_wen} !== 4'b0111)
         begin bad++; $display("FAIL exc_mstatus got=%b exp=0111", {i_mstatus_mie, i_mstatus_mie_wen, i_mstatus_mpie, i_mstatus_mpie_wen}); end
      total++; if (redirect_valid !== 1'b0 || flush !== 1'b1) begin bad++; $display("FAIL exc_T1_ctrl got=%b%b exp=01", redirect_valid, flush); end
      tick();
      total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin bad++; $display("FAIL exc_redirect got=%b/%h exp=1/200", redirect_valid, redirect_pc); end
      total++; if (i_mepc_value_wen !== 1'b0) begin bad++; $display("FAIL exc_T2_wen got=%b exp=0", i_mepc_value_wen); end
      redirect_ready = 1'b1;
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL exc_accept_flush got=%b exp=1", flush); end
      tick();
      redirect_ready = 1'b0;
      total++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h200)
         begin bad++; $display("FAIL exc_idle got=%b%b/%h exp=00/200", redirect_valid, flush, redirect_pc); end
   endtask

   task automatic test_timer_irq;
      mtvec_base = 30'hC0; mtvec_mode = 2'd1; mstatus_mie = 1'b1; mie_mtie = 1'b1;
      irq_timer = 1'b1; commit_valid = 1'b1; commit_pc = 32'h44;
      #1;
      total++; if (i_mip_mtip !== 1'b1 || i_mip_mtip_wen !== 1'b1) begin bad++; $display("FAIL irq_mip got=%b%b exp=11", i_mip_mtip, i_mip_mtip_wen); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL irq_flush_T got=%b exp=1", flush); end
      tick();
      commit_valid = 1'b0; irq_timer = 1'b0; mie_mtie = 1'b0;
      #1;
      total++; if ({i_mcause_interrupt, i_mcause_exception_code} !== 32'h80000007) begin bad++; $display("FAIL irq_mcause got=%h exp=80000007", {i_mcause_interrupt, i_mcause_exception_code}); end
      total++; if (i_mepc_value !== 32'h44 || i_mtval_value !== 32'h0 || i_mtval_value_wen !== 1'b1)
         begin bad++; $display("FAIL irq_mepc_mtval got=%h/%h exp=44/0", i_mepc_value, i_mtval_value); end
      tick();
      total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h31C) begin bad++; $display("FAIL irq_redirect got=%b/%h exp=1/31c", redirect_valid, redirect_pc); end
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
   endtask

   task automatic test_irq_priority;
      // MEI beats MSI
      mie_meie = 1'b1; mie_msie = 1'b1; irq_external = 1'b1; irq_software = 1'b1;
      commit_valid = 1'b1; commit_pc = 32'h60;
      tick();
      commit_valid = 1'b0; irq_external = 1'b0; irq_software = 1'b0;
      #1;
      total++; if ({i_mcause_interrupt, i_mcause_exception_code} !== 32'h8000000B) begin bad++; $display("FAIL prio_mei got=%h exp=8000000b", {i_mcause_interrupt, i_mcause_exception_code}); end
      tick();
      total++; if (redirect_pc !== 32'h32C) begin bad++; $display("FAIL prio_mei_target got=%h exp=32c", redirect_pc); end
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
      // MSI beats MTI
      mie_meie = 1'b0; mie_mtie = 1'b1; irq_software = 1'b1; irq_timer = 1'b1; commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0; irq_software = 1'b0; irq_timer = 1'b0;
      #1;
      total++; if ({i_mcause_interrupt, i_mcause_exception_code} !== 32'h80000003) begin bad++; $display("FAIL prio_msi got=%h exp=80000003", {i_mcause_interrupt, i_mcause_exception_code}); end
      tick();
      total++; if (redirect_pc !== 32'h30C) begin bad++; $display("FAIL prio_msi_target got=%h exp=30c", redirect_pc); end
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
      mie_msie = 1'b0; mie_mtie = 1'b0;
   endtask

   task automatic test_masking;
      mie_mtie = 1'b1; irq_timer = 1'b1; mstatus_mie = 1'b0; commit_valid = 1'b1;
      #1;
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL mask_mie_flush got=%b exp=0", flush); end
      tick();
      total++; if (i_mepc_value_wen !== 1'b0) begin bad++; $display("FAIL mask_mie_wen got=%b exp=0", i_mepc_value_wen); end
      mstatus_mie = 1'b1; commit_valid = 1'b0;
      #1;
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL mask_commit_flush got=%b exp=0", flush); end
      tick();
      total++; if (i_mepc_value_wen !== 1'b0 || redirect_valid !== 1'b0) begin bad++; $display("FAIL mask_commit_state got=%b%b exp=00", i_mepc_value_wen, redirect_valid); end
      irq_timer = 1'b0; mie_mtie = 1'b0;
   endtask

   task automatic test_exc_vs_irq;
      mtvec_base = 30'h80; mtvec_mode = 2'd0; mstatus_mie = 1'b1;
      mie_mtie = 1'b1; irq_timer = 1'b1; commit_valid = 1'b1; commit_pc = 32'h14;
      exc_valid = 1'b1; mret = 1'b1; exc_code = 5'd5; exc_pc = 32'h10; exc_tval = 32'h1234;
      tick();
      exc_valid = 1'b0; mret = 1'b0;
      #1;
      total++; if ({i_mcause_interrupt, i_mcause_exception_code} !== 32'h5 || i_mepc_value !== 32'h10)
         begin bad++; $display("FAIL exc_wins got=%h/%h exp=00000005/10", {i_mcause_interrupt, i_mcause_exception_code}, i_mepc_value); end
      tick();
      mstatus_mie = 1'b0; mstatus_mpie = 1'b1;  // mcsr applied the entry writes
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
      #1;
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL deferred_masked got=%b exp=0", flush); end
      mstatus_mie = 1'b1;
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL deferred_flush got=%b exp=1", flush); end
      tick();
      commit_valid = 1'b0; irq_timer = 1'b0; mie_mtie = 1'b0;
      #1;
      total++; if ({i_mcause_interrupt, i_mcause_exception_code} !== 32'h80000007 || i_mepc_value !== 32'h14)
         begin bad++; $display("FAIL deferred_taken got=%h/%h exp=80000007/14", {i_mcause_interrupt, i_mcause_exception_code}, i_mepc_value); end
      tick();
      total++; if (redirect_pc !== 32'h200) begin bad++; $display("FAIL deferred_target got=%h exp=200", redirect_pc); end
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
   endtask

   task automatic test_mret;
      mepc_value = 32'h80; mstatus_mpie = 1'b1; mstatus_mie = 1'b0;
      mret = 1'b1;
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL mret_flush_T got=%b exp=1", flush); end
      tick();
      mret = 1'b0;
      #1;
      total++; if ({i_mstatus_mie, i_mstatus_mie_wen, i_mstatus_mpie, i_mstatus_mpie_wen} !== 4'b1111)
         begin bad++; $display("FAIL mret_mstatus got=%b exp=1111", {i_mstatus_mie, i_mstatus_mie_wen, i_mstatus_mpie, i_mstatus_mpie_wen}); end
      total++; if (i_mepc_value_wen !== 1'b0 || i_mcause_interrupt_wen !== 1'b0) begin bad++; $display("FAIL mret_no_cause got=%b%b exp=00", i_mepc_value_wen, i_mcause_interrupt_wen); end
      tick();
      mepc_value = 32'h999;  // target must already be latched
      for (int i = 0; i < 3; i++) begin
         total++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h80)
            begin bad++; $display("FAIL mret_hold%0d got=%b%b/%h exp=11/80", i, redirect_valid, flush, redirect_pc); end
         tick();
      end
      redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
      total++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL mret_done got=%b%b exp=00", redirect_valid, flush); end
      mstatus_mie = 1'b1;
   endtask

   task automatic test_reset_mid;
      exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h500; exc_tval = 32'h0;
      tick();
      exc_valid = 1'b0;
      tick();
      total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rmid_in_redirect got=%b exp=1", redirect_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      total++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0)
         begin bad++; $display("FAIL rmid_cleared got=%b%b/%h exp=00/0", redirect_valid, flush, redirect_pc); end
      total++; if ({i_mepc_value_wen, i_mcause_exception_code_wen, i_mtval_value_wen, i_mstatus_mie_wen, i_mstatus_mpie_wen} !== 5'b0)
         begin bad++; $display("FAIL rmid_wen got=%b exp=00000", {i_mepc_value_wen, i_mcause_exception_code_wen, i_mtval_value_wen, i_mstatus_mie_wen, i_mstatus_mpie_wen}); end
      tick();
      total++; if (redirect_valid !== 1'b0 || i_mepc_value_wen !== 1'b0) begin bad++; $display("FAIL rmid_stays_idle got=%b%b exp=00", redirect_valid, i_mepc_value_wen); end
   endtask

   initial begin
      rst = 1'b1; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
      mret = 1'b0; commit_valid = 1'b0; commit_pc = '0; mepc_value = '0;
      irq_software = 1'b0; irq_timer = 1'b0; irq_external = 1'b0;
      mstatus_mie = 1'b0; mstatus_mpie = 1'b0; mie_msie = 1'b0; mie_mtie = 1'b0; mie_meie = 1'b0;
      mtvec_base = '0; mtvec_mode = '0; redirect_ready = 1'b0;
      test_reset();
      test_exception();
      test_timer_irq();
      test_irq_priority();
      test_masking();
      test_exc_vs_irq();
      test_mret();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
